vvu_stream_core: RTL and testbench

VVU_STREAM_CORE -- requirements
Module: vvu_stream_core

---
 rtl/vvu_stream_core_if.sv | 50 +++++
 rtl/vvu_stream_core.sv | 120 ++++++++++++
 tb/tb_vvu_stream_core.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vvu_stream_core_if.sv
// Activation, weight and result streams of the vector unit.
// master drives the inputs and sinks results; slave is the core.
interface vvu_stream_core_if #(
   parameter int PE               = 4,
   parameter int SIMD             = 3,
   parameter int ACTIVATION_WIDTH = 8,
   parameter int WEIGHT_WIDTH     = 8,
   parameter int ACCU_WIDTH       = 20
);
   localparam int IN_W  = ((PE * SIMD * ACTIVATION_WIDTH + 7) / 8) * 8;
   localparam int WT_W  = ((PE * SIMD * WEIGHT_WIDTH + 7) / 8) * 8;
   localparam int OUT_W = ((PE * ACCU_WIDTH + 7) / 8) * 8;

   logic [IN_W-1:0]  s_axis_input_tdata;
   logic             s_axis_input_tvalid;
   logic             s_axis_input_tready;
   logic [WT_W-1:0]  s_axis_weights_tdata;
   logic             s_axis_weights_tvalid;
   logic             s_axis_weights_tready;
   logic [OUT_W-1:0] m_axis_output_tdata;
   logic             m_axis_output_tvalid;
   logic             m_axis_output_tready;
   logic             m_axis_output_tlast;

   modport master (
      output s_axis_input_tdata,
      output s_axis_input_tvalid,
      input  s_axis_input_tready,
      output s_axis_weights_tdata,
      output s_axis_weights_tvalid,
      input  s_axis_weights_tready,
      input  m_axis_output_tdata,
      input  m_axis_output_tvalid,
      output m_axis_output_tready,
      input  m_axis_output_tlast
   );

   modport slave (
      input  s_axis_input_tdata,
      input  s_axis_input_tvalid,
      output s_axis_input_tready,
      input  s_axis_weights_tdata,
      input  s_axis_weights_tvalid,
      output s_axis_weights_tready,
      output m_axis_output_tdata,
      output m_axis_output_tvalid,
      input  m_axis_output_tready,
      output m_axis_output_tlast
   );
endinterface

// File: rtl/vvu_stream_core.sv
// Streaming vector unit: PE dot products of SIMD taps per beat,
// accumulated over SF beats, NF outputs per frame.
module vvu_stream_core #(
   parameter int PE                 = 4,
   parameter int SIMD               = 3,
   parameter int SF                 = 3,
   parameter int NF                 = 128,
   parameter int ACTIVATION_WIDTH   = 8,
   parameter int WEIGHT_WIDTH       = 8,
   parameter int ACCU_WIDTH         = 20,
   parameter int SIGNED_ACTIVATIONS = 0,
   parameter int INTERLEAVED        = 1
) (
   input logic              ap_clk,
   input logic              ap_rst,
   vvu_stream_core_if.slave bus
);
   localparam int AW    = ACTIVATION_WIDTH;
   localparam int WW    = WEIGHT_WIDTH;
   localparam int CW    = ACCU_WIDTH;
   localparam int OUT_W = ((PE * CW + 7) / 8) * 8;
   localparam int SF_W  = (SF > 1) ? $clog2(SF) : 1;
   localparam int NF_W  = (NF > 1) ? $clog2(NF) : 1;
   localparam logic [SF_W-1:0] SF_LAST = SF_W'(SF - 1);
   localparam logic [NF_W-1:0] NF_LAST = NF_W'(NF - 1);

   generate
      if (CW < AW + WW) begin : g_bad_accu
         $fatal(1, "ACCU_WIDTH too narrow for one product");
      end
      if (PE == 0 || SIMD == 0 || SF == 0 || NF == 0) begin : g_bad_dims
         $fatal(1, "PE, SIMD, SF and NF must be non-zero");
      end
   endgenerate

   logic [SF_W-1:0]  sf_cnt;
   logic [NF_W-1:0]  nf_cnt;
   logic [CW-1:0]    acc     [PE];
   logic [CW-1:0]    acc_nxt [PE];
   logic [OUT_W-1:0] res_data;
   logic [OUT_W-1:0] out_data;
   logic             out_vld;
   logic             out_last;
   logic             grp_end;
   logic             space;
   logic             fire;

   // The last beat of a group may only enter if the result slot frees up.
   assign grp_end = (sf_cnt == SF_LAST);
   assign space   = !ap_rst &&
                    (!grp_end || !out_vld || bus.m_axis_output_tready);
   assign fire    = bus.s_axis_input_tvalid &&
                    bus.s_axis_weights_tvalid && space;

   assign bus.s_axis_input_tready   = bus.s_axis_weights_tvalid && space;
   assign bus.s_axis_weights_tready = bus.s_axis_input_tvalid && space;
   assign bus.m_axis_output_tdata   = out_data;
   assign bus.m_axis_output_tvalid  = out_vld;
   assign bus.m_axis_output_tlast   = out_last;

   // Add every tap product of the current beat onto the running sums.
   always_comb begin
      logic [AW-1:0]        a;
      logic signed [AW:0]   a_ext;
      logic signed [WW-1:0] w;
      logic signed [AW+WW:0] prod;
      int                   idx;
      a        = '0;
      a_ext    = '0;
      w        = '0;
      prod     = '0;
      idx      = 0;
      res_data = '0;
      for (int k = 0; k < PE; k++) begin
         acc_nxt[k] = acc[k];
         for (int l = 0; l < SIMD; l++) begin
            idx   = (INTERLEAVED != 0) ? k + l * PE : k * SIMD + l;
            a     = bus.s_axis_input_tdata[idx*AW +: AW];
            a_ext = (SIGNED_ACTIVATIONS != 0) ? {a[AW-1], a} : {1'b0, a};
            w     = bus.s_axis_weights_tdata[(k*SIMD+l)*WW +: WW];
            prod  = a_ext * w;
            acc_nxt[k] = acc_nxt[k] + CW'(prod);
         end
         res_data[k*CW +: CW] = acc_nxt[k];
      end
   end

   // Beat position in the group and the partial sums it has built.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         sf_cnt <= '0;
         for (int k = 0; k < PE; k++) acc[k] <= '0;
      end else if (fire) begin
         if (grp_end) begin
            sf_cnt <= '0;
            for (int k = 0; k < PE; k++) acc[k] <= '0;
         end else begin
            sf_cnt <= sf_cnt + 1'b1;
            for (int k = 0; k < PE; k++) acc[k] <= acc_nxt[k];
         end
      end
   end

   // One-deep result slot; a drain and a load in one cycle keep it full.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         out_vld  <= 1'b0;
         out_last <= 1'b0;
         out_data <= '0;
         nf_cnt   <= '0;
      end else if (fire && grp_end) begin
         out_vld  <= 1'b1;
         out_data <= res_data;
         out_last <= (nf_cnt == NF_LAST);
         nf_cnt   <= (nf_cnt == NF_LAST) ? '0 : nf_cnt + 1'b1;
      end else if (bus.m_axis_output_tready) begin
         out_vld  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_vvu_stream_core.sv
// Three configurations of vvu_stream_core driven by directed and
// random beats, checked against a sum-of-products queue model.
module tb_vvu_stream_core;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        iv   [3];
   logic        wv   [3];
   logic [47:0] ad   [3];
   logic [47:0] wd   [3];
   logic        ordy [3];
   logic        fired [3];

   int sf_c [3] = '{3, 3, 1};
   int nf_c [3] = '{4, 4, 4};
   int il_c [3] = '{1, 0, 1};
   int sg_c [3] = '{0, 0, 1};

   int          macc [3][2];
   int          bc [3];
   int          oc [3];
   logic [40:0] qd [3][16];
   int          qh [3];
   int          qt [3];
   int          qn [3];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  lastv;

   vvu_stream_core_if #(.PE(2), .SIMD(3), .ACTIVATION_WIDTH(8),
      .WEIGHT_WIDTH(8), .ACCU_WIDTH(20)) if0 ();
   vvu_stream_core_if #(.PE(2), .SIMD(3), .ACTIVATION_WIDTH(8),
      .WEIGHT_WIDTH(8), .ACCU_WIDTH(20)) if1 ();
   vvu_stream_core_if #(.PE(2), .SIMD(3), .ACTIVATION_WIDTH(8),
      .WEIGHT_WIDTH(8), .ACCU_WIDTH(20)) if2 ();

   assign if0.s_axis_input_tdata    = ad[0];
   assign if0.s_axis_input_tvalid   = iv[0];
   assign if0.s_axis_weights_tdata  = wd[0];
   assign if0.s_axis_weights_tvalid = wv[0];
   assign if0.m_axis_output_tready  = ordy[0];
   assign if1.s_axis_input_tdata    = ad[1];
   assign if1.s_axis_input_tvalid   = iv[1];
   assign if1.s_axis_weights_tdata  = wd[1];
   assign if1.s_axis_weights_tvalid = wv[1];
   assign if1.m_axis_output_tready  = ordy[1];
   assign if2.s_axis_input_tdata    = ad[2];
   assign if2.s_axis_input_tvalid   = iv[2];
   assign if2.s_axis_weights_tdata  = wd[2];
   assign if2.s_axis_weights_tvalid = wv[2];
   assign if2.m_axis_output_tready  = ordy[2];

   vvu_stream_core #(.PE(2), .SIMD(3), .SF(3), .NF(4),
      .ACTIVATION_WIDTH(8), .WEIGHT_WIDTH(8), .ACCU_WIDTH(20),
      .SIGNED_ACTIVATIONS(0), .INTERLEAVED(1))
   u0 (.ap_clk(clk), .ap_rst(rst), .bus(if0));

   vvu_stream_core #(.PE(2), .SIMD(3), .SF(3), .NF(4),
      .ACTIVATION_WIDTH(8), .WEIGHT_WIDTH(8), .ACCU_WIDTH(20),
      .SIGNED_ACTIVATIONS(0), .INTERLEAVED(0))
   u1 (.ap_clk(clk), .ap_rst(rst), .bus(if1));

   vvu_stream_core #(.PE(2), .SIMD(3), .SF(1), .NF(4),
      .ACTIVATION_WIDTH(8), .WEIGHT_WIDTH(8), .ACCU_WIDTH(20),
      .SIGNED_ACTIVATIONS(1), .INTERLEAVED(1))
   u2 (.ap_clk(clk), .ap_rst(rst), .bus(if2));

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] rnd48();
      return {16'($urandom), $urandom};
   endfunction

   function automatic int beat(input int d, input int k,
                               input logic [47:0] a,
                               input logic [47:0] w);
      int s;
      int idx;
      int ae;
      int we;
      s = 0;
      for (int l = 0; l < 3; l++) begin
         idx = (il_c[d] != 0) ? k + l * 2 : k * 3 + l;
         if (sg_c[d] != 0) ae = int'($signed(a[idx*8 +: 8]));
         else              ae = int'(a[idx*8 +: 8]);
         we = int'($signed(w[(k*3+l)*8 +: 8]));
         s += ae * we;
      end
      return s;
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 3; d++) begin
         macc[d][0] = 0;
         macc[d][1] = 0;
         bc[d] = 0;
         oc[d] = 0;
         qh[d] = 0;
         qt[d] = 0;
         qn[d] = 0;
      end
   endtask

   task automatic ingest(input int d);
      logic [40:0] r;
      for (int k = 0; k < 2; k++) macc[d][k] += beat(d, k, ad[d], wd[d]);
      bc[d]++;
      if (bc[d] == sf_c[d]) begin
         r = {(oc[d] % nf_c[d]) == nf_c[d] - 1,
              20'(macc[d][1]), 20'(macc[d][0])};
         qd[d][qt[d]] = r;
         qt[d] = (qt[d] + 1) % 16;
         qn[d]++;
         oc[d]++;
         bc[d] = 0;
         macc[d][0] = 0;
         macc[d][1] = 0;
      end
   endtask

   task automatic chk_dut(input int d, input logic irdy, input logic wrdy,
                          input logic ov, input logic [39:0] od,
                          input logic ol);
      logic        space;
      logic [40:0] h;
      space = (bc[d] != sf_c[d] - 1) || (qn[d] == 0) || ordy[d];
      check($sformatf("u%0d in_tready", d), 64'(irdy),
            64'(wv[d] && space));
      check($sformatf("u%0d w_tready", d), 64'(wrdy),
            64'(iv[d] && space));
      check($sformatf("u%0d out_tvalid", d), 64'(ov), 64'(qn[d] != 0));
      if (qn[d] != 0) begin
         h = qd[d][qh[d]];
         if (ov) begin
            check($sformatf("u%0d out_tdata", d), 64'(od), 64'(h[39:0]));
            check($sformatf("u%0d out_tlast", d), 64'(ol), 64'(h[40]));
         end
         if (ordy[d]) begin
            qh[d] = (qh[d] + 1) % 16;
            qn[d]--;
         end
      end
      fired[d] = iv[d] && wv[d] && space;
   endtask

   task automatic cyc();
      #2;
      chk_dut(0, if0.s_axis_input_tready, if0.s_axis_weights_tready,
              if0.m_axis_output_tvalid, if0.m_axis_output_tdata,
              if0.m_axis_output_tlast);
      chk_dut(1, if1.s_axis_input_tready, if1.s_axis_weights_tready,
              if1.m_axis_output_tvalid, if1.m_axis_output_tdata,
              if1.m_axis_output_tlast);
      chk_dut(2, if2.s_axis_input_tready, if2.s_axis_weights_tready,
              if2.m_axis_output_tvalid, if2.m_axis_output_tdata,
              if2.m_axis_output_tlast);
      @(posedge clk);
      for (int d = 0; d < 3; d++) if (fired[d]) ingest(d);
      @(negedge clk);
   endtask

   task automatic chk_rst(input int d, input logic ov, input logic ol,
                          input logic [39:0] od, input logic ir,
                          input logic wr);
      check($sformatf("u%0d rst tvalid", d), 64'(ov), 64'(0));
      check($sformatf("u%0d rst tlast", d), 64'(ol), 64'(0));
      check($sformatf("u%0d rst tdata", d), 64'(od), 64'(0));
      check($sformatf("u%0d rst in_tready", d), 64'(ir), 64'(0));
      check($sformatf("u%0d rst w_tready", d), 64'(wr), 64'(0));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b1;
         wv[d] = 1'b1;
         ordy[d] = 1'b1;
      end
      #2;
      chk_rst(0, if0.m_axis_output_tvalid, if0.m_axis_output_tlast,
              if0.m_axis_output_tdata, if0.s_axis_input_tready,
              if0.s_axis_weights_tready);
      chk_rst(1, if1.m_axis_output_tvalid, if1.m_axis_output_tlast,
              if1.m_axis_output_tdata, if1.s_axis_input_tready,
              if1.s_axis_weights_tready);
      chk_rst(2, if2.m_axis_output_tvalid, if2.m_axis_output_tlast,
              if2.m_axis_output_tdata, if2.s_axis_input_tready,
              if2.s_axis_weights_tready);
      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0;
         wv[d] = 1'b0;
      end
      rst = 1'b0;
      model_clear();
   endtask

   task automatic idle_all();
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0;
         wv[d] = 1'b0;
         ordy[d] = 1'b1;
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         ad[d] = '0;
         wd[d] = '0;
         fired[d] = 1'b0;
      end
      idle_all();
      model_clear();
      @(negedge clk);
      do_reset();

      // Saturated unsigned activations against most negative weights.
      idle_all();
      iv[0] = 1'b1;
      wv[0] = 1'b1;
      ad[0] = {6{8'hFF}};
      wd[0] = {6{8'h80}};
      for (int i = 0; i < 9; i++) begin
         cyc();
         if (i % 3 == 2) begin
            #1;
            check("sat tvalid", 64'(if0.m_axis_output_tvalid), 64'(1));
            check("sat tdata", 64'(if0.m_axis_output_tdata),
                  64'(40'hB8480_B8480));
         end
      end
      idle_all();
      cyc();
      cyc();

      // Activation ordering: value equals index, unit weights.
      for (int d = 1; d < 3; d++) begin
         iv[d] = 1'b1;
         wv[d] = 1'b1;
         ad[d] = 48'h05_04_03_02_01_00;
         wd[d] = {6{8'h01}};
      end
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1;
         check("interleaved", 64'(if2.m_axis_output_tdata),
               64'(40'h00009_00006));
         if (i == 2)
            check("contiguous", 64'(if1.m_axis_output_tdata),
                  64'(40'h00024_00009));
      end
      idle_all();
      cyc();

      // Signed activation times signed weight, one beat per output.
      iv[2] = 1'b1;
      wv[2] = 1'b1;
      ad[2] = {6{8'hFF}};
      wd[2] = {6{8'hFF}};
      cyc();
      #1;
      check("signed", 64'(if2.m_axis_output_tdata), 64'(40'h00003_00003));
      idle_all();
      cyc();
      cyc();

      // Result held under back-pressure; only the group's last beat stalls.
      ordy[0] = 1'b0;
      iv[0] = 1'b1;
      wv[0] = 1'b1;
      ad[0] = rnd48();
      wd[0] = rnd48();
      for (int i = 0; i < 14; i++) begin
         cyc();
         if (fired[0]) begin
            ad[0] = rnd48();
            wd[0] = rnd48();
         end
      end
      #1;
      check("stall in_tready", 64'(if0.s_axis_input_tready), 64'(0));
      check("stall tvalid", 64'(if0.m_axis_output_tvalid), 64'(1));
      ordy[0] = 1'b1;
      cyc();
      #1;
      check("no bubble", 64'(if0.m_axis_output_tvalid), 64'(1));
      idle_all();
      cyc();
      cyc();

      // Reset in the middle of a group drops the partial sums.
      iv[0] = 1'b1;
      wv[0] = 1'b1;
      ad[0] = {6{8'h01}};
      wd[0] = {6{8'h02}};
      cyc();
      cyc();
      do_reset();
      iv[0] = 1'b1;
      wv[0] = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      #1;
      check("post-rst sum", 64'(if0.m_axis_output_tdata),
            64'(40'h00012_00012));
      idle_all();
      cyc();

      // Frame marker on every fourth output.
      iv[2] = 1'b1;
      wv[2] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ad[2] = rnd48();
         wd[2] = rnd48();
         cyc();
         #1;
         lastv[i] = if2.m_axis_output_tlast;
      end
      check("tlast pattern", 64'(lastv), 64'(8'b1000_1000));
      idle_all();
      cyc();

      // Random traffic with independent valids and random back-pressure.
      for (int i = 0; i < 600; i++) begin
         for (int d = 0; d < 3; d++) begin
            if (fired[d] || !(iv[d] || wv[d])) begin
               iv[d] = ($urandom % 4) != 0;
               wv[d] = ($urandom % 4) != 0;
               ad[d] = rnd48();
               wd[d] = rnd48();
            end else begin
               iv[d] = 1'b1;
               wv[d] = 1'b1;
            end
            ordy[d] = ($urandom % 3) != 0;
         end
         cyc();
      end
      idle_all();
      for (int i = 0; i < 4; i++) cyc();
      for (int d = 0; d < 3; d++)
         check($sformatf("u%0d drained", d), 64'(qn[d]), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
